// File: rtl/hq_seq_ctrl.sv
// Hq job sequencer: loads a 4x4 complex H, serves it to the multiplier and tags
// each result with {q,i,j}. Define HQ_SEQ_CTRL_OUT_FIFO_EN for an 8-deep output FIFO.
module hq_seq_ctrl #(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic                h_valid,
  output logic                h_ready,
  input  logic signed [N-1:0] h_r,
  input  logic signed [N-1:0] h_i,
  output logic                mm_start,
  output logic signed [N-1:0] mm_h_r,
  output logic signed [N-1:0] mm_h_i,
  input  logic [1:0]          mm_i_cnt,
  input  logic [1:0]          mm_k_cnt,
  input  logic                mm_hq_valid,
  input  logic                mm_one_done,
  input  logic                mm_all_done,
  input  logic signed [N-1:0] mm_hq_r,
  input  logic signed [N-1:0] mm_hq_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_r,
  output logic signed [N-1:0] out_i,
  output logic [3:0]          out_q,
  output logic [2:0]          out_ij,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int W = 2 * N + 7;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, FIN} state_t;

  state_t state_reg, state_next;

  logic [3:0] load_cnt_reg;
  logic [3:0] q_cnt_reg;
  logic [1:0] i_cnt_reg;
  logic       j_cnt_reg;
  logic [4:0] od_cnt_reg;
  logic       h_ready_reg, mm_start_reg, busy_reg, done_reg, err_reg;

  logic signed [N-1:0] hbuf_r [16];
  logic signed [N-1:0] hbuf_i [16];

  logic         load_fire, res_fire, res_stray, short_job;
  logic [4:0]   od_total;
  logic [W-1:0] res_word, out_word;
  logic         out_empty, fifo_drop, out_valid_int;

  assign load_fire = (state_reg == LOAD) && h_valid && h_ready_reg;
  assign res_fire  = (state_reg == RUN) && mm_hq_valid;
  assign res_stray = (state_reg != RUN) && mm_hq_valid;
  // One-done pulses are counted separately from q so that 16 pulses (q wrapped to 0) are distinguishable.
  assign od_total  = od_cnt_reg + {4'd0, mm_one_done};
  assign short_job = (state_reg == RUN) && mm_all_done && (od_total < 5'd16);
  assign res_word  = {mm_hq_r, mm_hq_i, q_cnt_reg, i_cnt_reg, j_cnt_reg};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (go) state_next = LOAD;
      LOAD:    if (load_fire && load_cnt_reg == 4'd15) state_next = RUN;
      RUN:     if (mm_all_done) state_next = FLUSH;
      FLUSH:   if (out_empty) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      load_cnt_reg <= 4'd0;
      q_cnt_reg    <= 4'd0;
      i_cnt_reg    <= 2'd0;
      j_cnt_reg    <= 1'b0;
      od_cnt_reg   <= 5'd0;
      h_ready_reg  <= 1'b0;
      mm_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      // Status outputs are registered from the next state so they track state_reg exactly.
      h_ready_reg  <= (state_next == LOAD);
      mm_start_reg <= (state_next == RUN);
      busy_reg     <= (state_next == LOAD) || (state_next == RUN) || (state_next == FLUSH);
      done_reg     <= (state_next == FIN);
      if (state_reg == IDLE && go) begin
        load_cnt_reg <= 4'd0;
        q_cnt_reg    <= 4'd0;
        i_cnt_reg    <= 2'd0;
        j_cnt_reg    <= 1'b0;
        od_cnt_reg   <= 5'd0;
      end
      if (load_fire) load_cnt_reg <= load_cnt_reg + 4'd1;
      if (res_fire) begin
        j_cnt_reg <= ~j_cnt_reg;
        if (j_cnt_reg) i_cnt_reg <= i_cnt_reg + 2'd1;
      end
      if (state_reg == RUN && mm_one_done) begin
        q_cnt_reg <= q_cnt_reg + 4'd1;
        if (od_cnt_reg != 5'd16) od_cnt_reg <= od_cnt_reg + 5'd1;
      end
      if (res_stray || short_job || fifo_drop) err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) begin
      hbuf_r[load_cnt_reg] <= h_r;
      hbuf_i[load_cnt_reg] <= h_i;
    end
  end

  assign mm_h_r = hbuf_r[{mm_i_cnt, mm_k_cnt}];
  assign mm_h_i = hbuf_i[{mm_i_cnt, mm_k_cnt}];

`ifdef HQ_SEQ_CTRL_OUT_FIFO_EN
  logic [W-1:0] fifo_mem [8];
  logic [2:0]   wr_ptr_reg, rd_ptr_reg;
  logic [3:0]   fifo_cnt_reg;
  logic         fifo_full, pop, push_ok;

  assign fifo_full = (fifo_cnt_reg == 4'd8);
  assign pop       = (fifo_cnt_reg != 4'd0) && out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = res_fire && (!fifo_full || pop);
  assign fifo_drop = res_fire && fifo_full && !pop;
  assign out_empty = (fifo_cnt_reg == 4'd0);
  assign out_valid_int = !out_empty;
  assign out_word  = out_valid_int ? fifo_mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= res_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= 3'd0;
      rd_ptr_reg   <= 3'd0;
      fifo_cnt_reg <= 4'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 3'd1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 3'd1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 4'd1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 4'd1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end
`else
  logic [W-1:0] out_word_reg;
  logic         out_valid_reg;
  logic         unused_out_ready;

  assign unused_out_ready = out_ready;
  assign fifo_drop        = 1'b0;
  assign out_empty        = 1'b1;
  assign out_valid_int    = out_valid_reg;
  assign out_word         = out_word_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      out_word_reg  <= '0;
    end else begin
      out_valid_reg <= res_fire;
      if (res_fire) out_word_reg <= res_word;
    end
  end
`endif

  assign out_valid = out_valid_int;
  assign {out_r, out_i, out_q, out_ij} = out_word;

  assign h_ready  = h_ready_reg;
  assign mm_start = mm_start_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule
